wave_spawner: RTL and testbench



---
 rtl/wave_spawner.sv | 198 +++++++++++++++++++
 tb/tb_wave_spawner.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wave_spawner.sv
// wave_spawner: decides each enabled frame whether to request a new alien
// from the event core, grouping aliens into waves separated by intermissions.
// Alien attributes come from an internal LFSR, so a reset replays the same run.
//
// Request protocol: spawn_object is a one-cycle pulse that the core
// edge-detects; spawn_data is valid while it is high and is held until the
// next pulse. There is no ready/back-pressure path other than object_count,
// which suppresses the attempt (retried every cycle) while the core is full.
package wave_spawner_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    INTER      = 3'd1,
    SPAWN      = 3'd2,
    WAIT_CLEAR = 3'd3,
    HALT       = 3'd4
  } spawner_state_t;

  typedef enum logic {
    INACTIVE = 1'b0,
    ACTIVE   = 1'b1
  } alien_state_t;

  typedef struct packed {
    alien_state_t _state;
    logic [3:0]   _r;
    logic [3:0]   _frame_num;
    logic [1:0]   _hp;
    logic [8:0]   _theta;
    logic [1:0]   _type;
  } alien_t;

  // Fibonacci LFSR, taps 16,14,13,11 (bits 0,2,3,5 of a right shifter).
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  // Folds a 9-bit angle into 0..359 with a single conditional subtract.
  function automatic logic [8:0] wrap_theta(input logic [8:0] t);
    return (t >= 9'd360) ? t - 9'd360 : t;
  endfunction

endpackage

module wave_spawner
  import wave_spawner_pkg::*;
#(
  parameter int OBJ_LIMIT    = 8,
  parameter int SPAWN_GAP    = 32,
  parameter int INTER_FRAMES = 90,
  parameter int WAVE_BASE    = 4,
  parameter int R_LIMIT      = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           all_clear,
  input  logic           game_over,
  input  logic [3:0]     object_count,
  output logic           spawn_object,
  output alien_t         spawn_data,
  output logic [7:0]     wave_num,
  output logic           wave_active,
  output spawner_state_t fsm_state,
  output logic [15:0]    lfsr
);

  // One shared counter: intermission, spawn gap or clear guard, by state.
  localparam int CNT_MAX = (INTER_FRAMES > SPAWN_GAP) ? INTER_FRAMES : SPAWN_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  spawner_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       remaining_q, remaining_d;
  logic [7:0]       wave_q, wave_d;
  logic [15:0]      lfsr_q;
  logic             spawn_q;
  logic             active_q;
  alien_t           data_q;

  logic       fire;
  logic       attempt;
  logic       can_spawn;
  logic [8:0] wave_sum;
  logic [3:0] wave_size;
  logic [3:0] rem_cur;
  logic [1:0] new_type;
  alien_t     alien_d;

  // Wave sizing, slot availability and the candidate alien record.
  always_comb begin
    wave_sum  = 9'(WAVE_BASE) + {1'b0, wave_q};
    wave_size = (wave_sum >= 9'd15) ? 4'd15 : wave_sum[3:0];
    can_spawn = ({28'd0, object_count} < 32'(OBJ_LIMIT));
    new_type  = (wave_q >= 8'd2) ? lfsr_q[1:0] : {1'b0, lfsr_q[0]};
    alien_d            = '0;
    alien_d._type      = new_type;
    alien_d._theta     = wrap_theta(lfsr_q[15:7]);
    alien_d._hp        = (new_type[1] ? 2'd2 : 2'd1) + ((wave_q >= 8'd4) ? 2'd1 : 2'd0);
    alien_d._frame_num = {new_type, 2'b00};
    alien_d._r         = 4'(R_LIMIT);
    alien_d._state     = ACTIVE;
  end

  // Next-state logic; the INTER->SPAWN edge doubles as the first attempt.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    remaining_d = remaining_q;
    wave_d      = wave_q;
    attempt     = 1'b0;
    fire        = 1'b0;
    rem_cur     = (state_q == INTER) ? wave_size : remaining_q;
    case (state_q)
      IDLE: begin
        state_d = INTER;
        cnt_d   = CNT_W'(INTER_FRAMES - 1);
      end
      INTER: begin
        if (cnt_q == '0) begin
          state_d     = SPAWN;
          remaining_d = wave_size;
          cnt_d       = '0;
          attempt     = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SPAWN: begin
        if (cnt_q == '0) attempt = 1'b1;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      WAIT_CLEAR: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (all_clear) begin
          wave_d  = (wave_q == 8'hFF) ? wave_q : wave_q + 8'd1;
          state_d = INTER;
          cnt_d   = CNT_W'(INTER_FRAMES - 1);
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (attempt && can_spawn) begin
      fire        = 1'b1;
      remaining_d = rem_cur - 4'd1;
      cnt_d       = CNT_W'(SPAWN_GAP - 1);
      if (rem_cur == 4'd1) begin
        // Guard spans the core's onepulse stage and registered slot update.
        state_d = WAIT_CLEAR;
        cnt_d   = CNT_W'(3);
      end
    end
    if ((state_q != IDLE) && game_over) begin
      state_d = HALT;
      fire    = 1'b0;
    end
  end

  // State and output registers; everything freezes while en is low
  // except the request pulse, which always returns low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      remaining_q <= '0;
      wave_q      <= '0;
      lfsr_q      <= 16'hACE1;
      spawn_q     <= 1'b0;
      active_q    <= 1'b0;
      data_q      <= '0;
    end else if (en) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      remaining_q <= remaining_d;
      wave_q      <= wave_d;
      lfsr_q      <= lfsr_step(lfsr_q);
      spawn_q     <= fire;
      active_q    <= (state_d == SPAWN) || (state_d == WAIT_CLEAR);
      if (fire) data_q <= alien_d;
    end else begin
      spawn_q <= 1'b0;
    end
  end

  assign spawn_object = spawn_q;
  assign spawn_data   = data_q;
  assign wave_num     = wave_q;
  assign wave_active  = active_q;
  assign fsm_state    = state_q;
  assign lfsr         = lfsr_q;

endmodule

// File: tb/tb_wave_spawner.sv
// Directed bench for wave_spawner with short intermission/gap parameters.
module tb_wave_spawner;
  import wave_spawner_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           all_clear = 1'b0;
  logic           game_over = 1'b0;
  logic [3:0]     object_count = 4'd0;
  logic           spawn_object;
  alien_t         spawn_data;
  logic [7:0]     wave_num;
  logic           wave_active;
  spawner_state_t fsm_state;
  logic [15:0]    lfsr;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [7:0]  exp_wave = 8'd0;
  alien_t      last_exp = '0;
  int          p;

  wave_spawner #(
    .OBJ_LIMIT   (8),
    .SPAWN_GAP   (4),
    .INTER_FRAMES(4),
    .WAVE_BASE   (2),
    .R_LIMIT     (15)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .all_clear   (all_clear),
    .game_over   (game_over),
    .object_count(object_count),
    .spawn_object(spawn_object),
    .spawn_data  (spawn_data),
    .wave_num    (wave_num),
    .wave_active (wave_active),
    .fsm_state   (fsm_state),
    .lfsr        (lfsr)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [15:0] m_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  function automatic alien_t exp_alien(input logic [15:0] l, input logic [7:0] w);
    alien_t     a;
    logic [1:0] ty;
    logic [8:0] t;
    ty = (w >= 8'd2) ? l[1:0] : {1'b0, l[0]};
    t  = l[15:7];
    a            = '0;
    a._type      = ty;
    a._theta     = (t >= 9'd360) ? t - 9'd360 : t;
    a._hp        = ((ty >= 2'd2) ? 2'd2 : 2'd1) + ((w >= 8'd4) ? 2'd1 : 2'd0);
    a._frame_num = {ty, 2'b00};
    a._r         = 4'd15;
    a._state     = ACTIVE;
    return a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given en; any observed pulse has its record checked
  // against the model LFSR value from the cycle of the pulse.
  task automatic tick(input logic en_v);
    logic [15:0] pre;
    en  = en_v;
    pre = m_lfsr;
    @(posedge clk);
    if (en_v) m_lfsr = m_step(m_lfsr);
    #1;
    if (spawn_object) begin
      last_exp = exp_alien(pre, exp_wave);
      chk("spawn_data", 32'(spawn_data), 32'(last_exp));
    end
  endtask

  task automatic run(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick(1'b1);
      if (spawn_object) pulses++;
    end
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_spawn_object", 32'(spawn_object), 32'd0);
    chk("rst_spawn_data", 32'(spawn_data), 32'd0);
    chk("rst_wave_num", 32'(wave_num), 32'd0);
    chk("rst_wave_active", 32'(wave_active), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'(IDLE));
    chk("rst_lfsr", 32'(lfsr), 32'hACE1);
    rst_n = 1'b1;

    // en low after reset: nothing moves
    for (int i = 0; i < 3; i++) tick(1'b0);
    chk("idle_frozen_state", 32'(fsm_state), 32'(IDLE));
    chk("idle_frozen_lfsr", 32'(lfsr), 32'(m_lfsr));

    // Wave 0: pulses on enabled cycles 5 and 9
    all_clear    = 1'b1;
    object_count = 4'd0;
    run(4, p);
    chk("no_pulse_inter", 32'(p), 32'd0);
    chk("inter_state", 32'(fsm_state), 32'(INTER));
    chk("inter_inactive", 32'(wave_active), 32'd0);
    tick(1'b1);
    chk("pulse_c5", 32'(spawn_object), 32'd1);
    chk("active_c5", 32'(wave_active), 32'd1);
    chk("spawn_state_c5", 32'(fsm_state), 32'(SPAWN));
    chk("wave0_type", 32'(spawn_data._type), 32'(last_exp._type));
    run(3, p);
    chk("gap_no_pulse", 32'(p), 32'd0);
    chk("data_hold", 32'(spawn_data), 32'(last_exp));
    tick(1'b1);
    chk("pulse_c9", 32'(spawn_object), 32'd1);
    chk("wait_clear_c9", 32'(fsm_state), 32'(WAIT_CLEAR));

    // Guard: all_clear already high, wave advances exactly 4 cycles later
    run(3, p);
    chk("guard_wave_num", 32'(wave_num), 32'd0);
    chk("guard_state", 32'(fsm_state), 32'(WAIT_CLEAR));
    tick(1'b1);
    chk("wave1_num", 32'(wave_num), 32'd1);
    chk("wave1_inter", 32'(fsm_state), 32'(INTER));
    chk("wave1_inactive", 32'(wave_active), 32'd0);
    exp_wave = 8'd1;

    // en low for 10 cycles mid-intermission
    tick(1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0);
    chk("pause_lfsr", 32'(lfsr), 32'(m_lfsr));
    chk("pause_state", 32'(fsm_state), 32'(INTER));
    chk("pause_no_pulse", 32'(spawn_object), 32'd0);
    run(2, p);
    chk("pause_resume_no_pulse", 32'(p), 32'd0);
    tick(1'b1);
    chk("pulse_c17", 32'(spawn_object), 32'd1);

    // Core full: attempts stall, then retry on the next cycle
    object_count = 4'd8;
    run(8, p);
    chk("full_no_pulse", 32'(p), 32'd0);
    chk("full_state", 32'(fsm_state), 32'(SPAWN));
    object_count = 4'd7;
    tick(1'b1);
    chk("retry_pulse", 32'(spawn_object), 32'd1);
    object_count = 4'd0;
    run(3, p);
    chk("wave1_gap", 32'(p), 32'd0);
    tick(1'b1);
    chk("wave1_third_pulse", 32'(spawn_object), 32'd1);
    chk("wave1_wait_clear", 32'(fsm_state), 32'(WAIT_CLEAR));
    run(3, p);
    chk("wave1_guard", 32'(wave_num), 32'd1);
    tick(1'b1);
    chk("wave2_num", 32'(wave_num), 32'd2);
    exp_wave = 8'd2;
    run(3, p);
    chk("wave2_inter", 32'(p), 32'd0);
    tick(1'b1);
    chk("wave2_pulse", 32'(spawn_object), 32'd1);

    // Asynchronous reset with the pulse high
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_spawn_object", 32'(spawn_object), 32'd0);
    chk("async_wave_num", 32'(wave_num), 32'd0);
    chk("async_wave_active", 32'(wave_active), 32'd0);
    chk("async_state", 32'(fsm_state), 32'(IDLE));
    chk("async_spawn_data", 32'(spawn_data), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    m_lfsr   = 16'hACE1;
    exp_wave = 8'd0;

    // game_over during SPAWN: terminal HALT
    run(4, p);
    chk("rerun_no_pulse", 32'(p), 32'd0);
    tick(1'b1);
    chk("rerun_pulse", 32'(spawn_object), 32'd1);
    game_over = 1'b1;
    tick(1'b1);
    chk("halt_state", 32'(fsm_state), 32'(HALT));
    chk("halt_inactive", 32'(wave_active), 32'd0);
    game_over = 1'b0;
    run(20, p);
    chk("halt_no_pulse", 32'(p), 32'd0);
    chk("halt_stays", 32'(fsm_state), 32'(HALT));

    // Angle folding, directed and along the LFSR sequence
    chk("theta_400", 32'(wrap_theta(9'd400)), 32'd40);
    chk("theta_359", 32'(wrap_theta(9'd359)), 32'd359);
    chk("theta_360", 32'(wrap_theta(9'd360)), 32'd0);
    chk("theta_511", 32'(wrap_theta(9'd511)), 32'd151);
    begin
      logic [15:0] v;
      int          bad;
      v   = 16'hACE1;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
        if (wrap_theta(v[15:7]) >= 9'd360) bad++;
        v = m_step(v);
      end
      chk("theta_range_1000", 32'(bad), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
